inst_fetch_arb: RTL and testbench
=================================

Name: inst_fetch_arb

Overview:
- Arbiter and controller for the single-port, combinational-read instruction ROM.
- Shares the ROM between two requesters:
  - the CPU fetch stage, as the `cpu_*` port;
  - the debug/boot-inspection port, as the `dbg_*` port.
- Drives the ROM chip-enable and address. Registers the returned word, giving each requester a 1-cycle-latency, single-cycle-throughput read channel.
- Sits between pc_reg/if_id and the ROM at the top level.

Parameters:
- ADDR_W, 32, byte-address width of both request ports and mem_addr.
- DATA_W, 32, instruction word width.
- LOCK_MAX, 16, maximum consecutive cycles the debug port may hold an exclusive lock.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU fetch request.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_gnt  out  1  CPU request accepted this cycle (combinational).
- cpu_flush  in  1  discard CPU response due next cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dbg_req  in  1  debug request.
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_lock  in  1  request exclusive ownership while asserted.
- dbg_gnt  out  1  debug request accepted (combinational).
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  debug read data.
- mem_ce  out  1  ROM enable; WriteEnable level when a grant is issued, else WriteDisable.
- mem_addr  out  ADDR_W  ROM address, the winner's address; 0 when idle.
- mem_inst  in  DATA_W  ROM word, combinational from mem_addr.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous, active-low.
  - While rst_n=0:
    - cpu_rvalid=0, dbg_rvalid=0;
    - cpu_rdata=dbg_rdata=ZeroWord;
    - state=ARB, last=DBG, lock_cnt=0.
  - gnt/mem outputs are combinational from state and inputs.
  - The block is gated to all-zero during reset.
- State machine, two states:
  - ARB:
    - Only one request: grant it.
    - Both requesting: round-robin against `last` — grant the requester not granted most recently.
    - Because last=DBG after reset, the CPU wins the first conflict.
    - `last` updates only on a grant.
    - Transition to DBG_LOCK when dbg_gnt=1 and dbg_lock=1; lock_cnt loads 1.
  - DBG_LOCK:
    - The debug port owns the ROM; cpu_gnt=0 regardless of cpu_req.
    - dbg_req is granted whenever asserted.
    - lock_cnt increments every cycle.
    - Return to ARB when dbg_lock=0 or lock_cnt==LOCK_MAX-1, with last=DBG.
    - After a LOCK_MAX timeout, the lock is ignored until dbg_lock deasserts for at least one cycle. A sticky lock_spent flag, cleared on dbg_lock=0, enforces this.
- Datapath:
  - Grant in cycle N drives mem_ce and mem_addr in N.
  - At the edge ending N, mem_inst is captured into the granted port's rdata.
  - That port's rvalid=1 in cycle N+1, for exactly one cycle unless regranted.
  - The non-granted port's rdata holds its value; its rvalid=0.
- Flush:
  - cpu_flush=1 in cycle N suppresses the cpu_rvalid that would assert in N+1; cpu_rdata is not updated.
  - A flush together with a new cpu_req in the same cycle still accepts the new request.
  - Flush has no effect on the debug port.
- No backpressure: requesters must accept rvalid when it asserts.
- Addresses are passed to the ROM unchanged; the ROM performs word indexing.
- Deasserting rst_n mid-transfer drops the pending rvalid, and rvalid stays 0 after reset release.

Optional Feature:
- Macro: INST_ARB_ALIGN_CHK_EN.
- When defined:
  - A granted request whose addr[1:0]!=0 does not enable the ROM: mem_ce at WriteDisable level.
  - The grant and round-robin update still occur.
  - Response in N+1: rvalid=1, rdata=ZeroWord, and new output port misalign_err=1 for that cycle.
  - misalign_err resets to 0.
- When undefined: no misalign_err port, and addr[1:0] is ignored.

Decomposition:
- Shared include/package define.v gains:
  - ARB_CPU/ARB_DBG owner codes;
  - ARB state encodings ArbIdle/ArbDbgLock;
  - LockMaxDefault.
  - Existing InstAddrBus, InstBus, ZeroWord and WriteEnable/WriteDisable are reused.
- One natural sub-module: rr_arb2. It is a 2-way round-robin picker taking req[1:0] and last, and producing gnt[1:0]. It is purely combinational and reusable for the future data-RAM port.

Test Plan:
- Reset release, cpu_req=1, cpu_addr=0x0000_0004, ROM word1=0x3401_0011 → cpu_gnt=1 and mem_addr=0x4 in cycle 0; cpu_rvalid=1, cpu_rdata=0x3401_0011 in cycle 1.
- Both ports request every cycle for 4 cycles → grants alternate CPU,DBG,CPU,DBG; each rvalid pulses 1 cycle later on the matching port.
- dbg_req=1 and dbg_lock=1 for 5 cycles with cpu_req=1 throughout → cpu_gnt=0 for all 5 cycles after lock entry; the CPU is granted the first cycle after dbg_lock falls.
- LOCK_MAX=4, dbg_lock held 10 cycles with cpu_req=1 → CPU granted on a conflict after 4 DBG lock cycles; grants alternate until dbg_lock drops.
- cpu_req at N with cpu_flush at N → no cpu_rvalid at N+1, cpu_rdata unchanged; new request at N+1 returns normally.
- With INST_ARB_ALIGN_CHK_EN, dbg_addr=0x0000_0006 → mem_ce disabled; at N+1 dbg_rvalid=1, dbg_rdata=0, misalign_err=1. rst_n pulsed low mid-response → rvalid=0 immediately and stays 0.

Source files
------------

// File: rtl/inst_fetch_arb_pkg.sv
// Shared definitions for the instruction-fetch arbiter: bus widths, owner
// codes, arbiter state encodings and ROM enable levels.
package inst_fetch_arb_pkg;

    localparam int unsigned InstAddrW = 32;
    localparam int unsigned InstW     = 32;

    typedef logic [InstAddrW-1:0] inst_addr_bus_t;
    typedef logic [InstW-1:0]     inst_bus_t;

    localparam inst_bus_t ZeroWord = '0;

    // ROM chip-enable levels
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    // Owner codes, also the bit index of each requester in rr_arb2
    localparam logic ARB_CPU = 1'b0;
    localparam logic ARB_DBG = 1'b1;

    localparam int unsigned LockMaxDefault = 16;

    typedef enum logic {
        ArbIdle    = 1'b0,
        ArbDbgLock = 1'b1
    } arb_state_e;

endpackage

// File: rtl/inst_fetch_arb_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req[1:0]  requests (bit 0 = ARB_CPU, bit 1 = ARB_DBG)
//   last      owner code of the most recent grant
//   gnt[1:0]  one-hot grant; on a conflict the side not granted last wins
module rr_arb2
    import inst_fetch_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (last == ARB_DBG));
        gnt[1] = req[1] & (~req[0] | (last == ARB_CPU));
    end

endmodule

// File: rtl/inst_fetch_arb.sv
// inst_fetch_arb: shares the single-port combinational instruction ROM between
// the CPU fetch port (cpu_*) and the debug port (dbg_*). Grants and ROM
// address are combinational; the ROM word is registered into the winner's
// rdata, giving 1-cycle latency at full throughput. The debug port can take
// an exclusive lock for at most LOCK_MAX cycles.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cpu_req/addr/flush -> cpu_gnt   CPU fetch request, flush drops next response
//   cpu_rvalid/rdata                CPU response
//   dbg_req/addr/lock -> dbg_gnt    debug request, lock requests exclusivity
//   dbg_rvalid/rdata                debug response
//   mem_ce/mem_addr <- mem_inst     ROM interface
// Optional: INST_ARB_ALIGN_CHK_EN adds misalign_err; misaligned grants leave
// the ROM disabled and return ZeroWord with misalign_err set.
module inst_fetch_arb
    import inst_fetch_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = InstAddrW,
    parameter int unsigned DATA_W   = InstW,
    parameter int unsigned LOCK_MAX = LockMaxDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    input  logic              cpu_flush,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
`ifdef INST_ARB_ALIGN_CHK_EN
    output logic              misalign_err,
`endif
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_inst
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_spent_q, lock_spent_d;

    logic             cpu_req_g, dbg_req_g;
    logic [1:0]       rr_gnt;
    logic             any_gnt;
    logic             cpu_rsp;
    logic [DATA_W-1:0] rsp_word;

    // Requests are gated so grants and ROM outputs stay zero in reset
    assign cpu_req_g = cpu_req & rst_n;
    assign dbg_req_g = dbg_req & rst_n;

    rr_arb2 u_rr_arb2 (
        .req  ({dbg_req_g, cpu_req_g}),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    // Grant selection: lock bypasses round-robin entirely
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (state_q == ArbDbgLock) begin
            dbg_gnt = dbg_req_g;
        end else begin
            cpu_gnt = rr_gnt[0];
            dbg_gnt = rr_gnt[1];
        end
    end

    assign any_gnt = cpu_gnt | dbg_gnt;
    assign cpu_rsp = cpu_gnt & ~cpu_flush;

    // ROM drive
    always_comb begin
        mem_addr = '0;
        if (dbg_gnt) begin
            mem_addr = dbg_addr;
        end else if (cpu_gnt) begin
            mem_addr = cpu_addr;
        end
    end

`ifdef INST_ARB_ALIGN_CHK_EN
    logic misaligned;
    assign misaligned = (mem_addr[1:0] != 2'b00);
    assign mem_ce     = (any_gnt & ~misaligned) ? WriteEnable : WriteDisable;
    assign rsp_word   = misaligned ? DATA_W'(ZeroWord) : mem_inst;
`else
    assign mem_ce     = any_gnt ? WriteEnable : WriteDisable;
    assign rsp_word   = mem_inst;
`endif

    // Next-state: lock entry/exit, owner history, lock timeout bookkeeping
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        lock_cnt_d   = lock_cnt_q;
        lock_spent_d = lock_spent_q & dbg_lock;
        if (cpu_gnt) last_d = ARB_CPU;
        if (dbg_gnt) last_d = ARB_DBG;
        unique case (state_q)
            ArbIdle: begin
                if (dbg_gnt && dbg_lock && !lock_spent_q) begin
                    state_d    = ArbDbgLock;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            ArbDbgLock: begin
                last_d     = ARB_DBG;
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                if (!dbg_lock) begin
                    state_d    = ArbIdle;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    // Timeout: lock ignored until dbg_lock drops
                    state_d      = ArbIdle;
                    lock_cnt_d   = '0;
                    lock_spent_d = 1'b1;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ArbIdle;
            last_q       <= ARB_DBG;
            lock_cnt_q   <= '0;
            lock_spent_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_spent_q <= lock_spent_d;
        end
    end

    // Response registers; the non-granted side holds its rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= DATA_W'(ZeroWord);
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= DATA_W'(ZeroWord);
        end else begin
            cpu_rvalid <= cpu_rsp;
            dbg_rvalid <= dbg_gnt;
            if (cpu_rsp) cpu_rdata <= rsp_word;
            if (dbg_gnt) dbg_rdata <= rsp_word;
        end
    end

`ifdef INST_ARB_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (cpu_rsp | dbg_gnt) & misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_arb.sv
// Self-checking bench for inst_fetch_arb: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_inst_fetch_arb;
    import inst_fetch_arb_pkg::*;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LOCK_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req, cpu_flush, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dbg_req, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_ce;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_inst;
`ifdef INST_ARB_ALIGN_CHK_EN
    logic              misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                m_last_dbg;
    bit                m_locked;
    int                m_sess_len;
    bit                m_spent;
    logic [DATA_W-1:0] exp_cpu_rd, exp_dbg_rd;

    inst_fetch_arb #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_flush  (cpu_flush),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_lock   (dbg_lock),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
`ifdef INST_ARB_ALIGN_CHK_EN
        .misalign_err (misalign_err),
`endif
        .mem_ce     (mem_ce),
        .mem_addr   (mem_addr),
        .mem_inst   (mem_inst)
    );

    always #5 clk = ~clk;

    // ROM contents: word 1 is fixed, the rest derived from the address
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a[ADDR_W-1:2] == 30'd1) return 32'h3401_0011;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_inst = rom_word(mem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last_dbg = 1'b1;
        m_locked   = 1'b0;
        m_sess_len = 0;
        m_spent    = 1'b0;
        exp_cpu_rd = '0;
        exp_dbg_rd = '0;
    endtask

    // One clock of traffic; entered and left at posedge+1
    task automatic run_cycle(input bit creq, input logic [ADDR_W-1:0] caddr, input bit flush,
                             input bit dreq, input logic [ADDR_W-1:0] daddr, input bit dlock);
        bit ecg, edg, tmo, ecv;
        logic [ADDR_W-1:0] eaddr;
        cpu_req   = creq;
        cpu_addr  = caddr;
        cpu_flush = flush;
        dbg_req   = dreq;
        dbg_addr  = daddr;
        dbg_lock  = dlock;
        if (m_locked) begin
            ecg = 1'b0;
            edg = dreq;
        end else if (creq && dreq) begin
            ecg = m_last_dbg;
            edg = !m_last_dbg;
        end else begin
            ecg = creq;
            edg = dreq;
        end
        eaddr = edg ? daddr : (ecg ? caddr : '0);
        #1;
        check_eq("cpu_gnt", 32'(cpu_gnt), 32'(ecg));
        check_eq("dbg_gnt", 32'(dbg_gnt), 32'(edg));
        check_eq("mem_ce", 32'(mem_ce), 32'(ecg | edg));
        check_eq("mem_addr", mem_addr, eaddr);
        @(posedge clk);
        #1;
        if (ecg) m_last_dbg = 1'b0;
        if (edg) m_last_dbg = 1'b1;
        tmo = 1'b0;
        if (m_locked) begin
            m_sess_len++;
            if (!dlock) m_locked = 1'b0;
            else if (m_sess_len == int'(LOCK_MAX)) begin
                m_locked = 1'b0;
                tmo      = 1'b1;
            end
        end else if (edg && dlock && !m_spent) begin
            m_locked   = 1'b1;
            m_sess_len = 1;
        end
        if (!dlock) m_spent = 1'b0;
        if (tmo) m_spent = 1'b1;
        ecv = ecg && !flush;
        if (ecv) exp_cpu_rd = rom_word(caddr);
        if (edg) exp_dbg_rd = rom_word(daddr);
        check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(ecv));
        check_eq("cpu_rdata", cpu_rdata, exp_cpu_rd);
        check_eq("dbg_rvalid", 32'(dbg_rvalid), 32'(edg));
        check_eq("dbg_rdata", dbg_rdata, exp_dbg_rd);
`ifdef INST_ARB_ALIGN_CHK_EN
        check_eq("misalign_err", 32'(misalign_err), 32'(0));
`endif
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once
    task automatic reset_pulse();
        @(negedge clk);
        rst_n    = 1'b0;
        cpu_req  = 1'b1;
        dbg_req  = 1'b1;
        cpu_addr = 32'h10;
        dbg_addr = 32'h20;
        #1;
        check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
        check_eq("rst_dbg_rvalid", 32'(dbg_rvalid), 32'(0));
        check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
        check_eq("rst_dbg_rdata", dbg_rdata, 32'h0);
        check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'(0));
        check_eq("rst_dbg_gnt", 32'(dbg_gnt), 32'(0));
        check_eq("rst_mem_ce", 32'(mem_ce), 32'(0));
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpu_req  = 1'b0;
        dbg_req  = 1'b0;
        dbg_lock = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("post_rst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
        check_eq("post_rst_dbg_rvalid", 32'(dbg_rvalid), 32'(0));
    endtask

    initial begin
        bit lock_run;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_flush = 1'b0;
        dbg_req   = 1'b0;
        dbg_addr  = '0;
        dbg_lock  = 1'b0;
        model_reset();
        reset_pulse();

        // First fetch after reset
        run_cycle(1, 32'h4, 0, 0, 32'h0, 0);
        check_eq("first_rdata", cpu_rdata, 32'h3401_0011);

        // Both request: alternate grants
        for (int i = 0; i < 4; i++)
            run_cycle(1, 32'h100 + 32'(i * 4), 0, 1, 32'h200 + 32'(i * 4), 0);

        // Lock held past LOCK_MAX with CPU requesting throughout
        for (int i = 0; i < 10; i++)
            run_cycle(1, 32'h300, 0, 1, 32'h400 + 32'(i * 4), 1);
        run_cycle(1, 32'h304, 0, 1, 32'h440, 0);

        // Short lock released before timeout
        for (int i = 0; i < 3; i++)
            run_cycle(1, 32'h308, 0, 1, 32'h500, 1);
        run_cycle(1, 32'h30C, 0, 0, 32'h0, 0);

        // Flush kills this response only; next request returns normally
        run_cycle(1, 32'h8, 1, 0, 32'h0, 0);
        run_cycle(1, 32'hC, 0, 0, 32'h0, 0);
        run_cycle(1, 32'h10, 1, 0, 32'h0, 0);
        run_cycle(1, 32'h14, 1, 1, 32'h24, 0);

        // Reset mid-response
        run_cycle(1, 32'h4, 0, 1, 32'h28, 0);
        reset_pulse();

        // Randomized traffic
        lock_run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) lock_run = !lock_run;
            run_cycle(bit'($urandom_range(0, 3) != 0), {$urandom_range(0, 255), 2'b00}, bit'($urandom_range(0, 4) == 0),
                      bit'($urandom_range(0, 2) != 0), {$urandom_range(0, 255), 2'b00}, lock_run);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
